// File: rtl/neorv32_boot_banner_pkg.sv
// Shared constants for the boot-banner UART stand-in.
// Latency: n/a (constants, types and a constant function only).
// Backpressure: n/a.
// Contents: banner length and ROM, TX/RX state encodings, bit-period divider helper.
package neorv32_boot_banner_pkg;

   localparam int BANNER_LEN = 11;

   // "\r\nNEORV32\r\n"
   localparam logic [7:0] BANNER_ROM [BANNER_LEN] = '{
      8'h0D, 8'h0A, 8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32, 8'h0D, 8'h0A
   };

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Clock cycles per UART bit, truncated.
   function automatic int unsigned calc_div(input int unsigned clock_freq,
                                            input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/neorv32_uart_tx_core.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit, each DIV cycles.
// Latency: start bit appears on txd the cycle after a byte is accepted in IDLE.
// Backpressure: byte_rdy is high only in IDLE; a byte is taken when byte_vld && byte_rdy.
// Ports: core_clk/arst_n clock and async active-low reset; byte_dat/byte_vld/byte_rdy
//        input byte handshake; txd serial line straight from a flop (idle high).
module neorv32_uart_tx_core
   import neorv32_boot_banner_pkg::*;
#(
   parameter int unsigned DIV = 5208
)(
   input  logic       core_clk,
   input  logic       arst_n,
   input  logic [7:0] byte_dat,
   input  logic       byte_vld,
   output logic       byte_rdy,
   output logic       txd
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   // The stop bit's final cycle is spent in IDLE, so a waiting byte can start
   // its start bit immediately after a full-length stop bit.
   localparam logic [CW-1:0] STOP_LAST = CW'(DIV - 2);

   tx_state_t      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     sh_q, sh_d;
   logic           txd_q, txd_d;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      txd_d   = txd_q;
      unique case (state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (byte_vld) begin
               sh_d    = byte_dat;
               txd_d   = 1'b0;
               cnt_d   = '0;
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               txd_d   = sh_q[0];
               sh_d    = {1'b0, sh_q[7:1]};
               state_d = TX_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = TX_STOP;
               end else begin
                  txd_d = sh_q[0];
                  sh_d  = {1'b0, sh_q[7:1]};
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            if (cnt_q == STOP_LAST) begin
               cnt_d   = '0;
               state_d = TX_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign byte_rdy = (state_q == TX_IDLE);
   assign txd      = txd_q;

endmodule

// File: rtl/neorv32_boot_banner_uart.sv
// NEORV32 pin-compatible stand-in: sends "\r\nNEORV32\r\n" after reset, then echoes valid RX bytes.
// Latency: banner starts one bit period after reset release; echo starts the cycle after TX is idle.
// Backpressure: none on RX; a 1-entry holding register is overwritten by newer bytes.
// Ports: clk_i core clock; rstn_i async active-low reset; uart0_rxd_i async serial in (idle high);
//        uart0_txd_o serial out (idle high, driven from a flop).
module neorv32_boot_banner_uart
   import neorv32_boot_banner_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 100000000,
   parameter int unsigned BAUD_RATE  = 19200
)(
   input  logic clk_i,
   input  logic rstn_i,
   input  logic uart0_rxd_i,
   output logic uart0_txd_o
);

   localparam int unsigned DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
   localparam int CW = $clog2(DIV + 1);
   localparam logic [CW-1:0] LEAD_LAST = CW'(DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
   localparam logic [3:0]    IDX_LAST  = 4'(BANNER_LEN - 1);

   // ---------------- banner sequencer ----------------
   logic [CW-1:0] lead_cnt_q;
   logic [3:0]    idx_q;
   logic          last_loaded_q;
   logic          echo_q;
   logic          lead_done;
   logic          banner_vld;

   // ---------------- echo holding register ----------------
   logic          hold_vld_q;
   logic [7:0]    hold_dat_q;

   // ---------------- TX handshake ----------------
   logic          tx_vld;
   logic          tx_rdy;
   logic [7:0]    tx_dat;

   // ---------------- RX path ----------------
   logic          sync1_q, sync2_q, prev_q;
   logic          rearm_q;
   logic          fall;
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_byte_vld;
   logic          rx_frame_err;

   // Lead-in counter saturates at DIV; the first start bit begins on the
   // cycle after it saturates, giving exactly one idle bit after release.
   assign lead_done  = (lead_cnt_q == LEAD_LAST);
   assign banner_vld = lead_done && !last_loaded_q;

   assign tx_vld = echo_q ? hold_vld_q : banner_vld;
   assign tx_dat = echo_q ? hold_dat_q : BANNER_ROM[idx_q];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lead_cnt_q    <= '0;
         idx_q         <= '0;
         last_loaded_q <= 1'b0;
         echo_q        <= 1'b0;
      end else begin
         if (!lead_done) begin
            lead_cnt_q <= lead_cnt_q + CW'(1);
         end
         if (banner_vld && tx_rdy) begin
            if (idx_q == IDX_LAST) begin
               last_loaded_q <= 1'b1;
            end else begin
               idx_q <= idx_q + 4'd1;
            end
         end
         // TX back in IDLE after the last banner byte means its stop bit is done.
         if (last_loaded_q && tx_rdy) begin
            echo_q <= 1'b1;
         end
      end
   end

   // A byte completing in the same cycle TX takes the register wins the
   // register; TX has already sampled the old contents through tx_dat.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         hold_vld_q <= 1'b0;
         hold_dat_q <= '0;
      end else if (rx_byte_vld && echo_q) begin
         hold_vld_q <= 1'b1;
         hold_dat_q <= rx_sh_q;
      end else if (echo_q && hold_vld_q && tx_rdy) begin
         hold_vld_q <= 1'b0;
      end
   end

   neorv32_uart_tx_core #(
      .DIV (DIV)
   ) u_tx (
      .core_clk (clk_i),
      .arst_n   (rstn_i),
      .byte_dat (tx_dat),
      .byte_vld (tx_vld),
      .byte_rdy (tx_rdy),
      .txd      (uart0_txd_o)
   );

   // Synchronizer flops clear to 0 so a line that is low from reset never
   // looks like a falling edge and never arms the receiver.
   assign fall = prev_q && !sync2_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         prev_q     <= 1'b0;
         rearm_q    <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         sync1_q    <= uart0_rxd_i;
         sync2_q    <= sync1_q;
         prev_q     <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         // After a framing error the line must go high before the next frame.
         if (rx_frame_err) begin
            rearm_q <= 1'b0;
         end else if (rx_state_q == RX_IDLE && sync2_q) begin
            rearm_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_sh_d      = rx_sh_q;
      rx_byte_vld  = 1'b0;
      rx_frame_err = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rearm_q && fall) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               // High at mid start bit: a glitch, not a frame.
               rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d     = '0;
               rx_state_d   = RX_IDLE;
               rx_byte_vld  = sync2_q;
               rx_frame_err = !sync2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_neorv32_boot_banner_uart.sv
// Testbench for neorv32_boot_banner_uart, run at a fast bit rate (16 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_neorv32_boot_banner_uart;

   localparam int DIV = 16;  // 100 MHz / 6.25 Mbaud

   logic clk_i       = 1'b0;
   logic rstn_i      = 1'b0;
   logic uart0_rxd_i = 1'b0;
   logic uart0_txd_o;

   int     errors = 0;
   int     checks = 0;
   longint cyc    = 0;
   longint rx_stop_cyc = 0;

   typedef struct {
      logic [7:0] rx;
      logic       stop;
      logic       echo;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] exp_banner [11];

   logic [7:0] mon_q [$];
   longint     mon_t [$];
   logic [7:0] mon_d;
   longint     mon_t0;

   neorv32_boot_banner_uart #(
      .CLOCK_FREQ (100000000),
      .BAUD_RATE  (6250000)
   ) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .uart0_rxd_i (uart0_rxd_i),
      .uart0_txd_o (uart0_txd_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Serial receiver on the TX line; samples at bit centres on the falling clock edge.
   initial begin
      forever begin
         @(negedge clk_i);
         if (uart0_txd_o === 1'b0) begin
            mon_t0 = cyc;
            repeat (DIV / 2) @(negedge clk_i);
            if (uart0_txd_o === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (DIV) @(negedge clk_i);
                  mon_d[i] = uart0_txd_o;
               end
               repeat (DIV) @(negedge clk_i);
               if (uart0_txd_o === 1'b1) begin
                  mon_q.push_back(mon_d);
                  mon_t.push_back(mon_t0);
               end
            end
         end
      end
   end

   task automatic clear_mon();
      mon_q.delete();
      mon_t.delete();
   endtask

   task automatic wait_bytes(input string name, input int n, input int budget);
      int k;
      k = 0;
      while (mon_q.size() < n && k < budget) begin
         @(posedge clk_i);
         k++;
      end
      check(name, 32'(mon_q.size()), 32'(n));
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      @(posedge clk_i); #1;
      uart0_rxd_i = 1'b0;
      repeat (DIV) @(posedge clk_i); #1;
      for (int i = 0; i < 8; i++) begin
         uart0_rxd_i = d[i];
         repeat (DIV) @(posedge clk_i); #1;
      end
      uart0_rxd_i = stop;
      rx_stop_cyc = cyc;
      repeat (DIV) @(posedge clk_i); #1;
      uart0_rxd_i = 1'b1;
   endtask

   task automatic check_banner(input string tag);
      wait_bytes({tag, "_count"}, 11, 200 * DIV);
      for (int i = 0; i < 11; i++) begin
         if (i < mon_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(mon_q[i]), 32'(exp_banner[i]));
      end
   endtask

   initial begin
      int     hi, lo, bad;
      longint rel, dly;

      exp_banner = '{8'h0D, 8'h0A, 8'h4E, 8'h45, 8'h4F, 8'h52, 8'h56, 8'h33, 8'h32, 8'h0D, 8'h0A};
      vecs[0] = '{8'h41, 1'b1, 1'b1};
      vecs[1] = '{8'h55, 1'b0, 1'b0};
      vecs[2] = '{8'h5A, 1'b1, 1'b1};
      vecs[3] = '{8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'hFF, 1'b1, 1'b1};
      vecs[5] = '{8'h80, 1'b1, 1'b1};

      // Reset 100 ns with RX tied low.
      #50;
      check("reset_txd", 32'(uart0_txd_o), 32'd1);
      #50;
      rstn_i = 1'b1;
      rel = cyc;

      hi = 0;
      while (hi < 4 * DIV) begin
         @(posedge clk_i); #1;
         if (uart0_txd_o !== 1'b1) break;
         hi++;
      end
      check("lead_in_cycles", 32'(hi), 32'(DIV));
      lo = 1;
      while (lo < 4 * DIV) begin
         @(posedge clk_i); #1;
         if (uart0_txd_o !== 1'b0) break;
         lo++;
      end
      check("start_bit_cycles", 32'(lo), 32'(DIV));

      check_banner("banner");
      if (mon_t.size() >= 9)
         check("neorv32_deadline", 32'((mon_t[8] + 10 * DIV - rel) < 288 * DIV), 32'd1);

      // Constant-low RX: nothing more should appear.
      repeat (192 * DIV) @(posedge clk_i);
      check("quiet_after_banner", 32'(mon_q.size()), 32'd11);

      // Echo vectors.
      #1 uart0_rxd_i = 1'b1;
      repeat (3 * DIV) @(posedge clk_i);
      for (int v = 0; v < 6; v++) begin
         clear_mon();
         send_frame(vecs[v].rx, vecs[v].stop);
         repeat (14 * DIV) @(posedge clk_i);
         check($sformatf("echo%0d_count", v), 32'(mon_q.size()), 32'(vecs[v].echo));
         if (vecs[v].echo && mon_q.size() > 0) begin
            check($sformatf("echo%0d_data", v), 32'(mon_q[0]), 32'(vecs[v].rx));
            dly = mon_t[0] - rx_stop_cyc;
            check($sformatf("echo%0d_latency", v), 32'(dly > 0 && dly <= DIV / 2 + 3 + 2 * DIV), 32'd1);
         end
      end

      // Back-to-back RX bytes while an echo is in flight.
      clear_mon();
      send_frame(8'h30, 1'b1);
      send_frame(8'h31, 1'b1);
      send_frame(8'h32, 1'b1);
      wait_bytes("b2b_count", 3, 40 * DIV);
      repeat (12 * DIV) @(posedge clk_i);
      check("b2b_no_dup", 32'(mon_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < mon_q.size()) check($sformatf("b2b_byte%0d", i), 32'(mon_q[i]), 32'(8'h30 + i));
      end

      // Reset during the 4th banner character.
      @(posedge clk_i); #1;
      rstn_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      clear_mon();
      rstn_i = 1'b1;
      wait_bytes("pre_reset_count", 3, 100 * DIV);
      repeat (4 * DIV) @(posedge clk_i);
      #1;
      rstn_i = 1'b0;
      bad = 0;
      #1;
      if (uart0_txd_o !== 1'b1) bad++;
      for (int i = 0; i < 12 * DIV; i++) begin
         @(posedge clk_i); #1;
         if (uart0_txd_o !== 1'b1) bad++;
      end
      check("txd_high_in_reset", 32'(bad), 32'd0);
      clear_mon();
      rstn_i = 1'b1;
      check_banner("restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/neorv32_boot_banner_uart.md
Name: neorv32_boot_banner_uart

Overview:
Minimal stand-in for the NEORV32 processor top. It has the same pin-out as the processor wrapper: clock, reset, and the UART0 RX/TX pair. After every reset release it sends the boot banner "\r\nNEORV32\r\n" over UART0 (8N1, 19200 baud by default). After that it echoes every correctly framed byte received on uart0_rxd_i. It sits at chip top and is checked by a simulation UART receiver that looks for the 7-character sequence "NEORV32".

Parameters:
CLOCK_FREQ, 100000000, core clock frequency in Hz.
BAUD_RATE, 19200, UART bit rate for both RX and TX.

Ports:
clk_i  input  1  system clock, rising-edge active.
rstn_i  input  1  reset, asynchronous, active-low.
uart0_rxd_i  input  1  serial receive line; idle high; asynchronous to clk_i.
uart0_txd_o  output  1  serial transmit line; idle high.

Behaviour:
- Single clock domain: clk_i. Reset is asynchronous and active-low on rstn_i; every flop clears on rstn_i=0.
- Bit period: DIV = CLOCK_FREQ/BAUD_RATE, truncated to an integer (5208 at the defaults). Every TX bit lasts exactly DIV cycles.
- Reset values:
  - uart0_txd_o=1.
  - Banner index=0.
  - TX FSM IDLE, RX FSM IDLE.
  - Echo holding register empty.
  - RX rearm flag cleared.
- Start-up: after rstn_i rises, TX holds the line high for exactly one bit period. It then starts banner character 0.
- Banner ROM, 11 bytes in order: 0x0D 0x0A 0x4E 0x45 0x4F 0x52 0x56 0x33 0x32 0x0D 0x0A.
  - Characters are sent back to back: the next start bit immediately follows the previous stop bit.
  - Total banner time is 110 bit periods, about 5.73 ms at the defaults.
- TX frame: start bit 0, then data bits 0..7 LSB first, then one stop bit 1. No parity.
  - TX FSM states: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
  - A byte is loaded only in IDLE.
- Mode change: after the last banner byte's stop bit completes, the block enters ECHO mode permanently, until the next reset.
- RX path:
  - uart0_rxd_i passes through a 2-flop synchronizer.
  - RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized falling edge starts a frame, but only when the rearm flag is set. The rearm flag sets when the synchronized line has been seen high at least once since reset or since the last frame.
  - START: sample at DIV/2 cycles. If the line is high, abort to IDLE (glitch).
  - DATA: sample data bits every DIV cycles, LSB first.
  - STOP: sample the stop bit. Stop=1 gives a valid byte. Stop=0 is a framing error: the byte is discarded and the rearm flag is cleared.
  - As a result, a line held constantly low produces no bytes and no echo.
  - RX runs during the banner, but bytes received before ECHO mode are discarded.
- Echo:
  - In ECHO mode a valid RX byte is written into a 1-entry holding register.
  - TX sends the held byte as soon as TX is IDLE.
  - If a new byte arrives while the register is still full, the new byte overwrites the old one.
  - If a byte completes in the same cycle that TX takes the register, TX takes the old byte and the new byte stays held.
- Reset mid-operation:
  - uart0_txd_o goes to 1 combinationally-free, i.e. directly from the reset flop, while rstn_i=0.
  - Any partial frame is abandoned.
  - The banner restarts from byte 0 after release, including the one-bit idle lead-in.
- No other outputs and no interrupts.

Decomposition:
- Package neorv32_boot_banner_pkg holds:
  - banner length constant (11);
  - banner ROM contents as a constant array;
  - TX and RX state encodings;
  - a function computing DIV from CLOCK_FREQ and BAUD_RATE.
- Sub-module neorv32_uart_tx_core: baud counter, shift register and FSM, with a byte/valid/ready handshake. It is instantiated once.
- RX, banner sequencer and echo register stay in the top.

Test Plan:
- Reset held 100 ns at 100 MHz, uart0_rxd_i tied to 0:
  - the received byte stream is 0x0D 0x0A 'N' 'E' 'O' 'R' 'V' '3' '2' 0x0D 0x0A;
  - "NEORV32" is complete before 15 ms;
  - no further bytes arrive in the following 10 ms (constant-low RX produces no echo).
- Timing check:
  - uart0_txd_o stays high for 5208 cycles after reset release;
  - the first start-bit low lasts exactly 5208 cycles;
  - the first byte decodes as 0x0D.
- After the banner, drive 0x41 as an 8N1 frame at 19200 baud on RX -> 0x41 is echoed on TX, with its start bit within 2 bit periods after the RX stop-bit sample.
- Frame with stop bit 0 (0x55, stop=0), then the line high, then 0x5A -> only 0x5A is echoed.
- Assert rstn_i during the 4th banner character:
  - uart0_txd_o is 1 throughout reset;
  - after release the banner restarts from 0x0D and completes fully.
- Send two back-to-back RX bytes 0x31 0x32 while an echo is in progress -> the bytes echo in order, with no byte duplicated.
